// File: rtl/frame_acc_pkg.sv
// Shared definitions for the frame accumulator: FSM state encoding,
// default geometry and the 32-bit saturation value.
package frame_acc_pkg;

  typedef enum logic {
    ACCUM  = 1'b0,
    OUTPUT = 1'b1
  } acc_state_e;

  localparam int FRAME_LEN_DEF = 256;
  localparam int ACC_W_DEF     = 48;

  localparam logic [31:0] SAT_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/frame_acc_sat.sv
// Narrows the wide frame sum to the 32-bit result.
// FRAME_ACC_SATURATE_EN defined   : sums above 0xFFFF_FFFF clip to all-ones, o_sat=1.
// FRAME_ACC_SATURATE_EN undefined : plain truncation to sum[31:0], o_sat=0.
module frame_acc_sat
  import frame_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] sum,
  output logic [31:0]      data,
  output logic             sat
);

`ifdef FRAME_ACC_SATURATE_EN
  // Clip when any bit above the 32-bit result range is set
  always_comb begin
    data = sum[31:0];
    sat  = 1'b0;
    if (|sum[ACC_W-1:32]) begin
      data = SAT_ONES;
      sat  = 1'b1;
    end
  end
`else
  // Upper bits are intentionally dropped: the result wraps
  logic unused_upper;
  assign unused_upper = ^sum[ACC_W-1:32];
  assign data = sum[31:0];
  assign sat  = 1'b0;
`endif

endmodule

// File: rtl/frame_accumulator.sv
// Sums FRAME_LEN unsigned 32-bit beats into one result and hands it
// downstream with a valid/ready handshake. The upstream is stalled while a
// result is pending. Result clipping is enabled by FRAME_ACC_SATURATE_EN
// (see frame_acc_sat).
//
// state  | meaning
// -------+------------------------------------------------------------
// ACCUM  | accepting beats (o_data_ready=1), summing into acc
// OUTPUT | result held on o_data until downstream takes it
module frame_accumulator
  import frame_acc_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int ACC_W     = ACC_W_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_data,
  input  logic        i_data_valid,
  output logic        o_data_ready,
  input  logic        i_clear,
  output logic [31:0] o_data,
  output logic        o_data_valid,
  input  logic        i_data_ready,
  output logic        o_sat
);

  localparam int CNT_W = $clog2(FRAME_LEN);

  acc_state_e        state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  sum;
  logic              last_beat;
  logic [31:0]       res_data;
  logic              res_sat;

  // Final sum includes the beat transferring this cycle
  assign sum       = acc + ACC_W'(i_data);
  assign last_beat = (cnt == CNT_W'(FRAME_LEN - 1));

  // Ready only while collecting beats; held low throughout reset
  assign o_data_ready = (state == ACCUM) && !i_rst;

  frame_acc_sat #(
    .ACC_W(ACC_W)
  ) u_sat (
    .sum (sum),
    .data(res_data),
    .sat (res_sat)
  );

  // Frame FSM: accumulate beats, latch the result, hold it for the handshake
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ACCUM;
      acc          <= '0;
      cnt          <= '0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_sat        <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (i_clear) begin
            acc <= '0;
            cnt <= '0;
          end else if (i_data_valid) begin
            if (last_beat) begin
              acc          <= '0;
              cnt          <= '0;
              o_data       <= res_data;
              o_sat        <= res_sat;
              o_data_valid <= 1'b1;
              state        <= OUTPUT;
            end else begin
              acc <= sum;
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        OUTPUT: begin
          if (i_data_ready) begin
            o_data_valid <= 1'b0;
            state        <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_accumulator.sv
// Bench for frame_accumulator with FRAME_LEN=4. A frame-level model
// (queue of accepted beats, summed when full) is checked on every cycle.
module tb_frame_accumulator;

  localparam int FL = 4;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] i_data;
  logic        i_data_valid;
  logic        o_data_ready;
  logic        i_clear;
  logic [31:0] o_data;
  logic        o_data_valid;
  logic        i_data_ready;
  logic        o_sat;

  int n_checks = 0;
  int n_err    = 0;
  int n_results = 0;

  frame_accumulator #(
    .FRAME_LEN(FL),
    .ACC_W    (48)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_data      (i_data),
    .i_data_valid(i_data_valid),
    .o_data_ready(o_data_ready),
    .i_clear     (i_clear),
    .o_data      (o_data),
    .o_data_valid(o_data_valid),
    .i_data_ready(i_data_ready),
    .o_sat       (o_sat)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  logic [31:0]     beats[$];
  logic            m_valid = 1'b0;
  logic [31:0]     m_data  = '0;
  logic            m_sat   = 1'b0;
  longint unsigned m_sum;

  // Compare DUT against the model mid-cycle, then advance the model using
  // the inputs that the coming rising edge will see
  always @(negedge i_clk) begin
    if (i_rst) begin
      chk("rst_valid", {63'd0, o_data_valid}, 64'd0);
      chk("rst_ready", {63'd0, o_data_ready}, 64'd0);
      chk("rst_data",  {32'd0, o_data}, 64'd0);
      chk("rst_sat",   {63'd0, o_sat}, 64'd0);
      beats.delete();
      m_valid = 1'b0;
    end else begin
      chk("valid", {63'd0, o_data_valid}, {63'd0, m_valid});
      chk("ready", {63'd0, o_data_ready}, {63'd0, !m_valid});
      if (m_valid) begin
        chk("data", {32'd0, o_data}, {32'd0, m_data});
        chk("sat",  {63'd0, o_sat}, {63'd0, m_sat});
      end
      if (m_valid) begin
        if (i_data_ready) begin
          m_valid = 1'b0;
          n_results++;
        end
      end else if (i_clear) begin
        beats.delete();
      end else if (i_data_valid) begin
        beats.push_back(i_data);
        if (beats.size() == FL) begin
          m_sum = 0;
          foreach (beats[i]) m_sum += beats[i];
`ifdef FRAME_ACC_SATURATE_EN
          if (m_sum > 64'hFFFF_FFFF) begin
            m_data = 32'hFFFF_FFFF;
            m_sat  = 1'b1;
          end else begin
            m_data = m_sum[31:0];
            m_sat  = 1'b0;
          end
`else
          m_data = m_sum[31:0];
          m_sat  = 1'b0;
`endif
          m_valid = 1'b1;
          beats.delete();
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Offer one beat and return #1 after the edge on which it transferred
  task automatic send(input logic [31:0] d);
    int waited = 0;
    i_data       = d;
    i_data_valid = 1'b1;
    @(negedge i_clk);
    while (!(o_data_ready && !i_rst) && waited < 50) begin
      waited++;
      @(negedge i_clk);
    end
    if (waited >= 50) begin
      n_checks++;
      n_err++;
      $display("FAIL send_timeout: got no ready expected ready within 50 cycles");
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Directed result check: DUT and model both pinned to a hand value
  task automatic expect_result(input string name, input logic [31:0] d, input logic s);
    chk({name, "_valid"}, {63'd0, o_data_valid}, 64'd1);
    chk({name, "_data"},  {32'd0, o_data}, {32'd0, d});
    chk({name, "_sat"},   {63'd0, o_sat}, {63'd0, s});
    chk({name, "_model"}, {32'd0, m_data}, {32'd0, d});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int start_res;
    int cyc;
    logic [31:0] big_exp;
    logic        big_sat;

    i_rst = 1'b1;
    i_data = '0;
    i_data_valid = 1'b0;
    i_clear = 1'b0;
    i_data_ready = 1'b1;

    repeat (3) @(posedge i_clk);
    #3 i_rst = 1'b0;
    step();
    chk("reset_ready", {63'd0, o_data_ready}, 64'd1);
    chk("reset_valid", {63'd0, o_data_valid}, 64'd0);
    chk("reset_data",  {32'd0, o_data}, 64'd0);

    // 1,2,3,4 with downstream ready: result 10 for exactly one cycle
    send(1); send(2); send(3); send(4);
    i_data_valid = 1'b0;
    expect_result("sum10", 32'd10, 1'b0);
    step();
    chk("sum10_one_cycle", {63'd0, o_data_valid}, 64'd0);

    // Downstream stalls 5 cycles; offered beat 9 must wait for the handshake
    i_data_ready = 1'b0;
    send(1); send(2); send(3); send(4);
    i_data_valid = 1'b1;
    i_data = 32'd9;
    for (int i = 0; i < 5; i++) begin
      chk("stall_data",  {32'd0, o_data}, 64'd10);
      chk("stall_ready", {63'd0, o_data_ready}, 64'd0);
      step();
    end
    i_data_ready = 1'b1;
    send(9); send(1); send(1); send(1);
    i_data_valid = 1'b0;
    expect_result("after_stall", 32'd12, 1'b0);
    step();

    // Overflowing frame
`ifdef FRAME_ACC_SATURATE_EN
    big_exp = 32'hFFFF_FFFF;
    big_sat = 1'b1;
`else
    big_exp = 32'hFFFF_FFFC;
    big_sat = 1'b0;
`endif
    for (int i = 0; i < 4; i++) send(32'hFFFF_FFFF);
    i_data_valid = 1'b0;
    expect_result("overflow", big_exp, big_sat);
    step();

    // Clear with a concurrent beat discards both the partial sum and the beat
    send(5); send(5);
    i_clear = 1'b1;
    send(7);
    i_clear = 1'b0;
    send(1); send(1); send(1); send(1);
    i_data_valid = 1'b0;
    expect_result("clear", 32'd4, 1'b0);
    step();

    // Clear while a result is pending is ignored
    i_data_ready = 1'b0;
    send(2); send(3); send(4); send(5);
    i_data_valid = 1'b0;
    i_clear = 1'b1;
    step(); step();
    i_clear = 1'b0;
    expect_result("clear_in_output", 32'd14, 1'b0);
    i_data_ready = 1'b1;
    step();

    // Async reset mid-frame, then a fresh frame
    send(3); send(3);
    i_data_valid = 1'b0;
    @(posedge i_clk);
    #3 i_rst = 1'b1;
    #1;
    chk("async_rst_ready", {63'd0, o_data_ready}, 64'd0);
    chk("async_rst_valid", {63'd0, o_data_valid}, 64'd0);
    @(posedge i_clk);
    #3 i_rst = 1'b0;
    step();
    send(2); send(2); send(2); send(2);
    i_data_valid = 1'b0;
    expect_result("after_rst", 32'd8, 1'b0);
    step();

    // Async reset while a result is held drops valid at once
    i_data_ready = 1'b0;
    send(6); send(6); send(6); send(6);
    i_data_valid = 1'b0;
    #2 i_rst = 1'b1;
    #1;
    chk("rst_in_output_valid", {63'd0, o_data_valid}, 64'd0);
    @(posedge i_clk);
    #3 i_rst = 1'b0;
    i_data_ready = 1'b1;
    step();
    send(1); send(2); send(2); send(1);
    i_data_valid = 1'b0;
    expect_result("after_rst2", 32'd6, 1'b0);
    step();

    // Random valid/ready traffic over 1000 frames
    start_res = n_results;
    cyc = 0;
    while (n_results < start_res + 1000 && cyc < 40000) begin
      i_data_valid = ($urandom_range(0, 3) != 0);
      i_data       = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | $urandom_range(0, 15) : $urandom;
      i_data_ready = ($urandom_range(0, 2) != 0);
      i_clear      = ($urandom_range(0, 99) == 0);
      step();
      cyc++;
    end
    i_data_valid = 1'b0;
    i_clear      = 1'b0;
    i_data_ready = 1'b1;
    chk("random_frames_done", {63'd0, n_results >= start_res + 1000}, 64'd1);
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
